// File: rtl/rx_gearbox_flex.sv
// Receive gearbox: repacks a continuous 64b/66b bitstream, DATA_WIDTH bits per
// cycle, into sync header plus payload words with a single-bit slip control.
module rx_gearbox_flex #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned HEADER_WIDTH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_data_valid,
  input  logic                    i_slip,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [HEADER_WIDTH-1:0] o_header,
  output logic                    o_data_valid,
  output logic                    o_header_valid,
  output logic                    o_slip_busy
);

  localparam int unsigned BLOCK_WIDTH = 66;
  localparam int unsigned BUF_WIDTH   = BLOCK_WIDTH + DATA_WIDTH;
  localparam int unsigned FILL_WIDTH  = 8;
  localparam int unsigned WORD_WIDTH  = DATA_WIDTH + HEADER_WIDTH;
  localparam logic        SPLIT_BLOCK = (DATA_WIDTH == 32);

  // Only the 32- and 64-bit datapaths with a 2-bit header are meaningful.
  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || HEADER_WIDTH != 2) begin : g_bad_param
    $error("rx_gearbox_flex: DATA_WIDTH must be 32 or 64 and HEADER_WIDTH must be 2");
  end

  logic [BUF_WIDTH-1:0]    acc_q, acc_d;
  logic [FILL_WIDTH-1:0]   fill_q, fill_d;
  logic                    phase_q, phase_d;
  logic                    slip_pend_q, slip_pend_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [HEADER_WIDTH-1:0] header_q, header_d;
  logic                    data_valid_q, data_valid_d;
  logic                    header_valid_q, header_valid_d;

  logic [BUF_WIDTH-1:0]    queue_c;
  logic [FILL_WIDTH-1:0]   fill_post_c;
  logic [FILL_WIDTH-1:0]   need_c;
  logic [FILL_WIDTH-1:0]   pop_c;
  logic                    apply_slip_c;
  logic [WORD_WIDTH-1:0]   word_c;

  // Append, emit decision, pop and slip bookkeeping.
  always_comb begin
    acc_d          = acc_q;
    fill_d         = fill_q;
    phase_d        = phase_q;
    slip_pend_d    = slip_pend_q;
    data_d         = data_q;
    header_d       = header_q;
    data_valid_d   = 1'b0;
    header_valid_d = 1'b0;
    queue_c        = acc_q;
    fill_post_c    = fill_q;

    // Bits above fill are kept zero, so new bits can be OR-ed in place.
    if (i_data_valid) begin
      queue_c     = acc_q | (BUF_WIDTH'(i_data) << fill_q);
      fill_post_c = fill_q + FILL_WIDTH'(DATA_WIDTH);
    end

    need_c       = phase_q ? FILL_WIDTH'(DATA_WIDTH) : FILL_WIDTH'(WORD_WIDTH);
    apply_slip_c = slip_pend_q && !phase_q;
    pop_c        = need_c + FILL_WIDTH'(apply_slip_c);
    // A pending slip drops the oldest bit in front of the header word.
    word_c       = WORD_WIDTH'(queue_c >> apply_slip_c);

    if (fill_post_c >= pop_c) begin
      data_valid_d = 1'b1;
      if (!phase_q) begin
        header_d       = word_c[HEADER_WIDTH-1:0];
        data_d         = word_c[WORD_WIDTH-1:HEADER_WIDTH];
        header_valid_d = 1'b1;
      end else begin
        data_d = word_c[DATA_WIDTH-1:0];
      end
      acc_d  = queue_c >> pop_c;
      fill_d = fill_post_c - pop_c;
      if (SPLIT_BLOCK) begin
        phase_d = ~phase_q;
      end
      if (apply_slip_c) begin
        slip_pend_d = 1'b0;
      end
    end else begin
      acc_d  = queue_c;
      fill_d = fill_post_c;
    end

    // New requests are only taken while no slip is outstanding.
    if (!slip_pend_q && i_slip) begin
      slip_pend_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q          <= '0;
      fill_q         <= '0;
      phase_q        <= 1'b0;
      slip_pend_q    <= 1'b0;
      data_q         <= '0;
      header_q       <= '0;
      data_valid_q   <= 1'b0;
      header_valid_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      fill_q         <= fill_d;
      phase_q        <= phase_d;
      slip_pend_q    <= slip_pend_d;
      data_q         <= data_d;
      header_q       <= header_d;
      data_valid_q   <= data_valid_d;
      header_valid_q <= header_valid_d;
    end
  end

  assign o_data         = data_q;
  assign o_header       = header_q;
  assign o_data_valid   = data_valid_q;
  assign o_header_valid = header_valid_q;
  assign o_slip_busy    = slip_pend_q;

  // The accumulator can never overflow given the pop sizes.
  a_fill_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (fill_post_c <= FILL_WIDTH'(BUF_WIDTH)));

endmodule

// File: tb/tb_rx_gearbox_flex.sv
// Bench for rx_gearbox_flex: 32- and 64-bit instances driven from a block-level
// bitstream source, checked against a bit-queue model and a word scoreboard.
module tb_rx_gearbox_flex;

  localparam int unsigned W32 = 32;
  localparam int unsigned W64 = 64;
  localparam logic [63:0] PAT    = 64'h0123456789ABCDEF;
  localparam logic [63:0] PAT_LO = 64'h0000000089ABCDEF;
  localparam logic [63:0] PAT_HI = 64'h0000000001234567;

  logic clk, rst_n;

  logic [W32-1:0] d32, o32_data;
  logic [1:0]     o32_hdr;
  logic           v32, s32, o32_dv, o32_hv, o32_busy;
  logic [W64-1:0] d64, o64_data;
  logic [1:0]     o64_hdr;
  logic           v64, s64, o64_dv, o64_hv, o64_busy;

  rx_gearbox_flex #(.DATA_WIDTH(W32)) u_dut32 (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(d32), .i_data_valid(v32), .i_slip(s32),
    .o_data(o32_data), .o_header(o32_hdr), .o_data_valid(o32_dv),
    .o_header_valid(o32_hv), .o_slip_busy(o32_busy));

  rx_gearbox_flex #(.DATA_WIDTH(W64)) u_dut64 (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(d64), .i_data_valid(v64), .i_slip(s64),
    .o_data(o64_data), .o_header(o64_hdr), .o_data_valid(o64_dv),
    .o_header_valid(o64_hv), .o_slip_busy(o64_busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks, n_errors;

  // Currently selected instance.
  bit          sel64;
  int          m_dw;
  logic [63:0] g_data;
  logic [1:0]  g_hdr;
  logic        g_dv, g_hv, g_busy;
  assign g_data = sel64 ? o64_data : {32'h0, o32_data};
  assign g_hdr  = sel64 ? o64_hdr  : o32_hdr;
  assign g_dv   = sel64 ? o64_dv   : o32_dv;
  assign g_hv   = sel64 ? o64_hv   : o32_hv;
  assign g_busy = sel64 ? o64_busy : o32_busy;

  // Model: the line bitstream as a queue, oldest bit at the front.
  bit          mq[$];
  int          m_phase;
  bit          m_pend;
  logic [63:0] e_data;
  logic [1:0]  e_hdr;
  logic        e_dv, e_hv, e_busy;

  // Source bitstream and the block-level word list it implies.
  bit          src[$];
  logic [66:0] exp_w[$];
  bit          sb_on;
  bit          rand_pat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic add_block();
    logic [1:0]  h;
    logic [63:0] p;
    if (rand_pat) begin
      h = 2'($urandom);
      p = {$urandom, $urandom};
    end else begin
      h = 2'b01;
      p = PAT;
    end
    for (int i = 0; i < 2; i++) src.push_back(h[i]);
    for (int i = 0; i < 64; i++) src.push_back(p[i]);
    if (m_dw == 32) begin
      exp_w.push_back({1'b1, h, 32'h0, p[31:0]});
      exp_w.push_back({1'b0, 2'b00, 32'h0, p[63:32]});
    end else begin
      exp_w.push_back({1'b1, h, p});
    end
  endtask

  task automatic model_reset();
    mq.delete();
    src.delete();
    exp_w.delete();
    m_phase = 0;
    m_pend  = 1'b0;
    e_data  = '0;
    e_hdr   = '0;
    e_dv    = 1'b0;
    e_hv    = 1'b0;
    e_busy  = 1'b0;
  endtask

  task automatic model_step(input logic [63:0] din, input bit dv, input bit slip);
    int need;
    int cost;
    bit pend0;
    pend0 = m_pend;
    if (dv) for (int i = 0; i < m_dw; i++) mq.push_back(din[i]);
    need = (m_phase == 0) ? m_dw + 2 : m_dw;
    cost = (m_phase == 0 && m_pend) ? 1 : 0;
    e_dv = 1'b0;
    e_hv = 1'b0;
    if (mq.size() >= need + cost) begin
      if (cost == 1) begin
        void'(mq.pop_front());
        m_pend = 1'b0;
      end
      e_data = '0;
      if (m_phase == 0) begin
        e_hdr = {mq[1], mq[0]};
        e_hv  = 1'b1;
        for (int i = 0; i < m_dw; i++) e_data[i] = mq[i+2];
      end else begin
        for (int i = 0; i < m_dw; i++) e_data[i] = mq[i];
      end
      for (int i = 0; i < need; i++) void'(mq.pop_front());
      e_dv = 1'b1;
      if (m_dw == 32) m_phase = 1 - m_phase;
    end
    if (slip && !pend0) m_pend = 1'b1;
    e_busy = m_pend;
  endtask

  task automatic drive_cycle(input bit v, input bit s);
    logic [63:0] din;
    logic [66:0] w;
    din = {$urandom, $urandom};
    if (v) begin
      while (src.size() < m_dw) add_block();
      for (int i = 0; i < m_dw; i++) din[i] = src.pop_front();
    end
    if (sel64) begin
      d64 = din; v64 = v; s64 = s;
      d32 = '0;  v32 = 1'b0; s32 = 1'b0;
    end else begin
      d32 = din[31:0]; v32 = v; s32 = s;
      d64 = '0;        v64 = 1'b0; s64 = 1'b0;
    end
    model_step(din, v, s);
    @(posedge clk);
    #1;
    chk("dv", g_dv, e_dv);
    chk("hv", g_hv, e_hv);
    chk("busy", g_busy, e_busy);
    if (e_dv) chk("data", g_data, e_data);
    if (e_hv) chk("hdr", g_hdr, e_hdr);
    if (sb_on && g_dv) begin
      if (exp_w.size() == 0) begin
        chk("sb_nonempty", 64'(exp_w.size() != 0), 64'd1);
      end else begin
        w = exp_w.pop_front();
        chk("sb_hv", g_hv, w[66]);
        if (w[66]) chk("sb_hdr", g_hdr, w[65:64]);
        chk("sb_data", g_data, w[63:0]);
      end
    end
  endtask

  task automatic do_reset(input bit is64);
    rst_n = 1'b0;
    sel64 = is64;
    m_dw  = is64 ? 64 : 32;
    model_reset();
    d32 = '0; v32 = 1'b0; s32 = 1'b0;
    d64 = '0; v64 = 1'b0; s64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst32_dv", o32_dv, 0);
    chk("rst32_hv", o32_hv, 0);
    chk("rst32_busy", o32_busy, 0);
    chk("rst32_data", o32_data, 0);
    chk("rst32_hdr", o32_hdr, 0);
    chk("rst64_dv", o64_dv, 0);
    chk("rst64_hv", o64_hv, 0);
    chk("rst64_busy", o64_busy, 0);
    chk("rst64_data", o64_data, 0);
    chk("rst64_hdr", o64_hdr, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Fixed-pattern word check, phase taken from the header-valid flag.
  task automatic chk_fixed_word(input string tag);
    if (g_hv) begin
      chk({tag, "_hdr"}, g_hdr, 2'b01);
      chk({tag, "_data"}, g_data, sel64 ? PAT : PAT_LO);
    end else begin
      chk({tag, "_is64"}, 64'(sel64), 64'd0);
      chk({tag, "_data1"}, g_data, PAT_HI);
    end
  endtask

  task automatic run_fixed(input bit is64);
    int seen;
    int nwin;
    do_reset(is64);
    sb_on = 1'b1; rand_pat = 1'b0; seen = 0; nwin = 0;
    for (int c = 1; c <= 363; c++) begin
      drive_cycle(1'b1, 1'b0);
      if (g_dv) begin
        if (is64 || (seen % 2) == 0) begin
          chk("fix_hv", g_hv, 1);
          chk("fix_hdr", g_hdr, 2'b01);
          chk("fix_data", g_data, is64 ? PAT : PAT_LO);
        end else begin
          chk("fix_hv1", g_hv, 0);
          chk("fix_data1", g_data, PAT_HI);
        end
        seen++;
        if (c >= 34) nwin++;
      end
    end
    chk("fix_rate", 64'(nwin), 64'd320);
  endtask

  task automatic run_slips(input bit is64, input int junk, input int nslip);
    int nhdr;
    do_reset(is64);
    sb_on = 1'b0; rand_pat = 1'b0; nhdr = 0;
    for (int i = 0; i < junk; i++) src.push_back(1'($urandom));
    repeat (6) drive_cycle(1'b1, 1'b0);
    for (int k = 0; k < nslip; k++) begin
      drive_cycle(1'b1, 1'b1);
      for (int t = 0; t < 20 && g_busy; t++) drive_cycle(1'b1, 1'b0);
      if (g_busy) chk("slip_timeout", g_busy, 0);
    end
    repeat (3) drive_cycle(1'b1, 1'b0);
    for (int c = 0; c < 100; c++) begin
      drive_cycle(1'b1, 1'b0);
      if (g_dv) begin
        chk_fixed_word("slip");
        if (g_hv) nhdr++;
      end
    end
    chk("slip_hdr_count", 64'(nhdr >= 40), 64'd1);
  endtask

  task automatic run_random(input bit is64, input bit with_slip);
    int nw;
    do_reset(is64);
    sb_on = !with_slip; rand_pat = 1'b1; nw = 0;
    for (int c = 0; c < 600; c++) begin
      if (with_slip) drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      else           drive_cycle(1'($urandom_range(0, 1)), 1'b0);
      if (g_dv) nw++;
    end
    chk("rand_words", 64'(nw >= 200), 64'd1);
  endtask

  task automatic run_reset_mid();
    int t;
    do_reset(1'b0);
    sb_on = 1'b1; rand_pat = 1'b1;
    repeat (40) drive_cycle(1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1);
    t = 0;
    while (!g_dv && t < 10) begin
      drive_cycle(1'b1, 1'b0);
      t++;
    end
    chk("rm_pre_dv", g_dv, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_dv", o32_dv, 0);
    chk("rm_hv", o32_hv, 0);
    chk("rm_busy", o32_busy, 0);
    chk("rm_data", o32_data, 0);
    chk("rm_hdr", o32_hdr, 0);
    model_reset();
    v32 = 1'b0; s32 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    while (!g_dv && t < 10) begin
      drive_cycle(1'b1, 1'b0);
      t++;
    end
    chk("rm_first_dv", g_dv, 1);
    chk("rm_first_hv", g_hv, 1);
    repeat (20) drive_cycle(1'b1, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    sel64    = 1'b0;
    m_dw     = 32;
    sb_on    = 1'b0;
    rand_pat = 1'b0;

    run_fixed(1'b0);
    run_fixed(1'b1);
    run_slips(1'b0, 5, 5);
    run_slips(1'b1, 5, 5);
    run_slips(1'b1, 0, 66);
    run_slips(1'b0, 0, 66);
    run_random(1'b0, 1'b0);
    run_random(1'b1, 1'b0);
    run_random(1'b0, 1'b1);
    run_random(1'b1, 1'b1);
    run_reset_mid();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
